// File: rtl/jtag_scan_pkg.sv
// Shared types and constants for the JTAG scan controller.
// TMS prefixes are stored LSB first: bit 0 is driven in the first TCK period.
package jtag_scan_pkg;

    typedef enum logic [2:0] {
        StRstTap,
        StIdle,
        StPre,
        StShift,
        StPost,
        StResp
    } scan_state_e;

    // Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [3:0] DrTmsPrefix = 4'b0001;
    localparam logic [2:0] DrPrefixLen = 3'd3;

    // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [3:0] IrTmsPrefix = 4'b0011;
    localparam logic [2:0] IrPrefixLen = 3'd4;

    localparam logic [2:0] TapResetLen = 3'd5;
    localparam logic [2:0] PostLen     = 3'd2;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: one TCK period is 2*TCK_DIV clocks, low phase first.
// Strobes mark the clocks on which TCK falls and rises; the counter idles at zero when disabled.
module jtag_tck_gen #(
    parameter int unsigned TCK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic fall_strobe,
    output logic rise_strobe,
    output logic tck
);

    localparam int unsigned CntW = $clog2(2 * TCK_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(2 * TCK_DIV - 1);
    localparam logic [CntW-1:0] CntRise = CntW'(TCK_DIV);

    logic [CntW-1:0] cnt_q;
    logic            tck_q;

    assign fall_strobe = enable && (cnt_q == '0);
    assign rise_strobe = enable && (cnt_q == CntRise);
    assign tck         = tck_q;

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
            if (rise_strobe) begin
                tck_q <= 1'b1;
            end else if (fall_strobe) begin
                tck_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jtag_scan_ctrl.sv
// JTAG scan controller: resets the TAP, then runs one IR or DR scan per request
// and returns the captured TDO bits through a valid/ready response.
module jtag_scan_ctrl
    import jtag_scan_pkg::*;
#(
    parameter int unsigned TCK_DIV = 4,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_is_ir,
    input  logic [6:0]         req_len,
    input  logic [MAX_LEN-1:0] req_tdi,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [MAX_LEN-1:0] resp_tdo,
    output logic               resp_undriven,
    output logic               jtag_TCK,
    output logic               jtag_TMS,
    output logic               jtag_TDI,
    output logic               jtag_TRSTn,
    input  logic               jtag_TDO_data,
    input  logic               jtag_TDO_driven,
    output logic               busy
);

    localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    scan_state_e        state_q;
    logic [2:0]         pcnt_q;
    logic [IdxW-1:0]    sidx_q;
    logic [IdxW-1:0]    cap_idx_q;
    logic               cap_pend_q;
    logic [3:0]         pre_tms_q;
    logic [2:0]         pre_len_q;
    logic [6:0]         len_q;
    logic [MAX_LEN-1:0] tdi_q;

    logic               tms_q;
    logic               tdi_out_q;
    logic               trst_n_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic [MAX_LEN-1:0] resp_tdo_q;
    logic               undriven_q;
    logic               busy_q;

    logic               tck_en;
    logic               fall_strobe;
    logic               rise_strobe;
    logic               tck;
    logic [6:0]         len_clamped;
    logic               last_bit;

    assign tck_en      = (state_q != StIdle) && (state_q != StResp);
    assign len_clamped = (req_len > 7'(MAX_LEN)) ? 7'(MAX_LEN) : req_len;
    assign last_bit    = (7'(sidx_q) == (len_q - 7'd1));

    jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clock       (clock),
        .reset       (reset),
        .enable      (tck_en),
        .fall_strobe (fall_strobe),
        .rise_strobe (rise_strobe),
        .tck         (tck)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StRstTap;
            pcnt_q       <= '0;
            sidx_q       <= '0;
            cap_idx_q    <= '0;
            cap_pend_q   <= 1'b0;
            pre_tms_q    <= '0;
            pre_len_q    <= '0;
            len_q        <= '0;
            tdi_q        <= '0;
            tms_q        <= 1'b1;
            tdi_out_q    <= 1'b0;
            trst_n_q     <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_tdo_q   <= '0;
            undriven_q   <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            // The last shift bit is sampled after the FSM has already moved on to POST.
            if (rise_strobe && cap_pend_q) begin
                resp_tdo_q[cap_idx_q] <= jtag_TDO_driven & jtag_TDO_data;
                if (!jtag_TDO_driven) begin
                    undriven_q <= 1'b1;
                end
                cap_pend_q <= 1'b0;
            end

            unique case (state_q)
                StRstTap: begin
                    if (fall_strobe) begin
                        if (pcnt_q == TapResetLen + 3'd1) begin
                            state_q     <= StIdle;
                            pcnt_q      <= '0;
                            req_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            tms_q     <= (pcnt_q < TapResetLen);
                            tdi_out_q <= 1'b0;
                            trst_n_q  <= (pcnt_q != 3'd0);
                            pcnt_q    <= pcnt_q + 3'd1;
                        end
                    end
                end

                StIdle: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        len_q       <= len_clamped;
                        tdi_q       <= req_tdi;
                        pre_tms_q   <= req_is_ir ? IrTmsPrefix : DrTmsPrefix;
                        pre_len_q   <= req_is_ir ? IrPrefixLen : DrPrefixLen;
                        resp_tdo_q  <= '0;
                        undriven_q  <= 1'b0;
                        pcnt_q      <= '0;
                        sidx_q      <= '0;
                        if (len_clamped == 7'd0) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= StPre;
                        end
                    end
                end

                StPre: begin
                    if (fall_strobe) begin
                        tms_q     <= pre_tms_q[pcnt_q[1:0]];
                        tdi_out_q <= 1'b0;
                        if (pcnt_q == pre_len_q - 3'd1) begin
                            state_q <= StShift;
                            pcnt_q  <= '0;
                        end else begin
                            pcnt_q <= pcnt_q + 3'd1;
                        end
                    end
                end

                StShift: begin
                    if (fall_strobe) begin
                        tdi_out_q  <= tdi_q[sidx_q];
                        tms_q      <= last_bit;
                        cap_pend_q <= 1'b1;
                        cap_idx_q  <= sidx_q;
                        if (last_bit) begin
                            state_q <= StPost;
                            pcnt_q  <= '0;
                        end else begin
                            sidx_q <= sidx_q + 1'b1;
                        end
                    end
                end

                StPost: begin
                    if (fall_strobe) begin
                        if (pcnt_q == PostLen) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                        end else begin
                            tms_q     <= (pcnt_q == 3'd0);
                            tdi_out_q <= 1'b0;
                            pcnt_q    <= pcnt_q + 3'd1;
                        end
                    end
                end

                StResp: begin
                    if (resp_ready) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StRstTap;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_tdo      = resp_tdo_q;
    assign resp_undriven = undriven_q;
    assign jtag_TCK      = tck;
    assign jtag_TMS      = tms_q;
    assign jtag_TDI      = tdi_out_q;
    assign jtag_TRSTn    = trst_n_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Randomized bench for jtag_scan_ctrl: a pin monitor records every TCK period and
// each scan is compared against TMS/TDI/TDO expectations derived from the scan rules.
module tb_jtag_scan_ctrl;

    localparam int unsigned TckDiv = 2;
    localparam int unsigned MaxLen = 64;
    localparam int          ObsN   = 8192;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_ir = 1'b0;
    logic [6:0]  req_len = '0;
    logic [63:0] req_tdi = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_tdo;
    logic        resp_undriven;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic        jtag_TDO_data, jtag_TDO_driven;
    logic        busy;

    // 0: loopback, 1: inverted loopback, 2: undriven, 3: driven only while TDI is 1
    int tdo_mode = 0;

    int n_tests = 0;
    int n_fail  = 0;

    assign jtag_TDO_data   = (tdo_mode == 1) ? ~jtag_TDI : jtag_TDI;
    assign jtag_TDO_driven = (tdo_mode == 2) ? 1'b0 : ((tdo_mode == 3) ? jtag_TDI : 1'b1);

    always #5 clock = ~clock;

    jtag_scan_ctrl #(
        .TCK_DIV (TckDiv),
        .MAX_LEN (MaxLen)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_ir       (req_is_ir),
        .req_len         (req_len),
        .req_tdi         (req_tdi),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_tdo        (resp_tdo),
        .resp_undriven   (resp_undriven),
        .jtag_TCK        (jtag_TCK),
        .jtag_TMS        (jtag_TMS),
        .jtag_TDI        (jtag_TDI),
        .jtag_TRSTn      (jtag_TRSTn),
        .jtag_TDO_data   (jtag_TDO_data),
        .jtag_TDO_driven (jtag_TDO_driven),
        .busy            (busy)
    );

    // Pin monitor: logs pins at every TCK rise and counts timing-rule violations.
    logic obs_tms  [ObsN];
    logic obs_tdi  [ObsN];
    logic obs_trst [ObsN];
    int   n_rise = 0;
    int   viol   = 0;
    int   hi_run = 0;
    logic prev_tck = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            hi_run <= 0;
        end else begin
            if (jtag_TCK && !prev_tck) begin
                obs_tms[n_rise % ObsN]  <= jtag_TMS;
                obs_tdi[n_rise % ObsN]  <= jtag_TDI;
                obs_trst[n_rise % ObsN] <= jtag_TRSTn;
                n_rise <= n_rise + 1;
            end
            if (jtag_TCK) begin
                hi_run <= hi_run + 1;
            end else if (prev_tck) begin
                if (hi_run != TckDiv) viol <= viol + 1;
                hi_run <= 0;
            end
            if (jtag_TCK && ((jtag_TMS !== prev_tms) || (jtag_TDI !== prev_tdi))) begin
                viol <= viol + 1;
            end
        end
        prev_tck <= jtag_TCK;
        prev_tms <= jtag_TMS;
        prev_tdi <= jtag_TDI;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tck"},      jtag_TCK, 1'b0);
        check_eq({tag, "_tms"},      jtag_TMS, 1'b1);
        check_eq({tag, "_tdi"},      jtag_TDI, 1'b0);
        check_eq({tag, "_trstn"},    jtag_TRSTn, 1'b0);
        check_eq({tag, "_req_rdy"},  req_ready, 1'b0);
        check_eq({tag, "_resp_vld"}, resp_valid, 1'b0);
        check_eq({tag, "_resp_tdo"}, resp_tdo, 64'h0);
        check_eq({tag, "_undriven"}, resp_undriven, 1'b0);
        check_eq({tag, "_busy"},     busy, 1'b1);
    endtask

    // Releases reset and checks the TAP reset sequence: TMS 1,1,1,1,1,0, TRSTn low in period 0.
    task automatic tap_reset_seq();
        int          base;
        int          k;
        int          got_n;
        int          saw_resp;
        logic [127:0] got_tms;
        logic [127:0] got_trst;
        @(negedge clock);
        base     = n_rise;
        saw_resp = 0;
        reset    = 1'b0;
        k        = 0;
        while (!req_ready && k < 300) begin
            @(negedge clock);
            if (resp_valid) saw_resp++;
            k++;
        end
        check_eq("tap_rst_ready", req_ready, 1'b1);
        @(negedge clock);
        got_n    = n_rise - base;
        got_tms  = '0;
        got_trst = '0;
        for (int i = 0; i < got_n && i < 128; i++) begin
            got_tms[i]  = obs_tms[(base + i) % ObsN];
            got_trst[i] = obs_trst[(base + i) % ObsN];
        end
        check_eq("tap_rst_pulses", got_n, 6);
        check_eq("tap_rst_tms", got_tms, 128'h1f);
        check_eq("tap_rst_trstn", got_trst, 128'h3e);
        check_eq("tap_rst_no_resp", saw_resp, 0);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_tck", jtag_TCK, 1'b0);
        check_eq("idle_tms", jtag_TMS, 1'b0);
        check_eq("idle_trstn", jtag_TRSTn, 1'b1);
    endtask

    task automatic run_scan(input logic is_ir, input logic [6:0] len, input logic [63:0] tdi,
                            input int mode, input int stall);
        int           eff, pre, exp_n, got_n, base, v0, k, unstable;
        logic [63:0]  exp_tdo, exp_tdi, snap_tdo;
        logic         exp_und, snap_und;
        logic [127:0] exp_tms, got_tms;
        logic [63:0]  got_tdi;

        // Reference model
        eff     = (int'(len) > MaxLen) ? MaxLen : int'(len);
        pre     = is_ir ? 4 : 3;
        exp_tdo = '0;
        exp_tdi = '0;
        exp_und = 1'b0;
        for (int i = 0; i < eff; i++) begin
            exp_tdi[i] = tdi[i];
            case (mode)
                0: exp_tdo[i] = tdi[i];
                1: exp_tdo[i] = ~tdi[i];
                2: exp_und = 1'b1;
                default: begin
                    if (tdi[i]) exp_tdo[i] = 1'b1;
                    else exp_und = 1'b1;
                end
            endcase
        end
        exp_tms = '0;
        exp_n   = 0;
        if (eff > 0) begin
            exp_tms[0] = 1'b1;
            if (is_ir) exp_tms[1] = 1'b1;
            exp_tms[pre + eff - 1] = 1'b1;
            exp_tms[pre + eff]     = 1'b1;
            exp_n = pre + eff + 2;
        end

        @(negedge clock);
        tdo_mode  = mode;
        base      = n_rise;
        v0        = viol;
        req_valid = 1'b1;
        req_is_ir = is_ir;
        req_len   = len;
        req_tdi   = tdi;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_is_ir = ~is_ir;
        req_len   = 7'($urandom);
        req_tdi   = {$urandom, $urandom};
        check_eq("accept_ready_low", req_ready, 1'b0);
        if (eff == 0) check_eq("len0_resp_next_clk", resp_valid, 1'b1);

        k = 0;
        while (!resp_valid && k < 600) begin
            @(negedge clock);
            k++;
        end
        check_eq("resp_arrives", resp_valid, 1'b1);
        snap_tdo = resp_tdo;
        snap_und = resp_undriven;
        unstable = 0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            if (resp_valid !== 1'b1 || resp_tdo !== snap_tdo || resp_undriven !== snap_und ||
                req_ready !== 1'b0 || jtag_TCK !== 1'b0) unstable++;
        end
        check_eq("resp_hold", unstable, 0);
        check_eq("resp_tdo", snap_tdo, exp_tdo);
        check_eq("resp_undriven", snap_und, exp_und);

        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        check_eq("back_idle_ready", req_ready, 1'b1);
        check_eq("back_idle_resp_vld", resp_valid, 1'b0);
        check_eq("back_idle_busy", busy, 1'b0);

        got_n   = n_rise - base;
        got_tms = '0;
        got_tdi = '0;
        for (int i = 0; i < got_n && i < 128; i++) got_tms[i] = obs_tms[(base + i) % ObsN];
        for (int i = 0; i < eff; i++) got_tdi[i] = obs_tdi[(base + pre + i) % ObsN];
        check_eq("tck_pulses", got_n, exp_n);
        check_eq("tms_seq", got_tms, exp_tms);
        check_eq("tdi_seq", got_tdi, exp_tdi);
        check_eq("pin_timing", viol - v0, 0);
        check_eq("idle_tms_low", jtag_TMS, 1'b0);
    endtask

    // Reset asserted while shift bit 3 of a DR scan is on the pins.
    task automatic abort_scan();
        int base, k, saw_resp;
        @(negedge clock);
        tdo_mode  = 0;
        base      = n_rise;
        req_valid = 1'b1;
        req_is_ir = 1'b0;
        req_len   = 7'd16;
        req_tdi   = {$urandom, $urandom};
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        k = 0;
        while ((n_rise - base) < 7 && k < 200) begin
            @(negedge clock);
            k++;
        end
        check_eq("abort_reached_bit3", (n_rise - base) >= 7, 1'b1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs("abort");
        saw_resp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (resp_valid) saw_resp++;
        end
        check_eq("abort_no_resp", saw_resp, 0);
        tap_reset_seq();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        tap_reset_seq();

        run_scan(1'b0, 7'd8, 64'hA5, 0, 0);
        run_scan(1'b1, 7'd5, 64'h11, 2, 0);
        run_scan(1'b0, 7'd64, {64{1'b1}}, 0, 20);
        run_scan(1'b0, 7'd0, {$urandom, $urandom}, 0, 3);
        run_scan(1'b1, 7'd100, {$urandom, $urandom}, 0, 1);
        run_scan(1'b0, 7'd1, 64'h1, 1, 0);

        for (int n = 0; n < 30; n++) begin
            logic [6:0] len;
            len = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(65, 127))
                                              : 7'($urandom_range(0, 64));
            run_scan(1'($urandom), len, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 5)));
        end

        abort_scan();
        run_scan(1'b1, 7'd12, {$urandom, $urandom}, 3, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got no finish, expected finish before 5ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jtag_scan_ctrl.md
JTAG_SCAN_CTRL -- requirements
Module: jtag_scan_ctrl

Interface
REQ-001 SHALL have parameter TCK_DIV, default 4: clocks per TCK half-period, legal range 1..255.
REQ-002 SHALL have parameter MAX_LEN, default 64: maximum scan length in bits.
REQ-003 SHALL have input clock, 1 bit: the single clock.
REQ-004 SHALL have input reset, 1 bit: synchronous, active-high.
REQ-005 SHALL have input req_valid, 1 bit, and output req_ready, 1 bit: scan request handshake.
REQ-006 SHALL have input req_is_ir, 1 bit: 1 selects an IR scan, 0 a DR scan.
REQ-007 SHALL have input req_len, 7 bits: scan length in bits, 0..MAX_LEN.
REQ-008 SHALL have input req_tdi, MAX_LEN bits: shift-in data, LSB shifted first.
REQ-009 SHALL have output resp_valid, 1 bit, and input resp_ready, 1 bit: response handshake.
REQ-010 SHALL have output resp_tdo, MAX_LEN bits, and output resp_undriven, 1 bit: captured data and undriven flag.
REQ-011 SHALL have outputs jtag_TCK, jtag_TMS, jtag_TDI and jtag_TRSTn, 1 bit each: the JTAG pins.
REQ-012 SHALL have inputs jtag_TDO_data and jtag_TDO_driven, 1 bit each: TDO value and its valid qualifier.
REQ-013 SHALL have output busy, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL build each TCK period from 2*TCK_DIV clocks: TCK low for TCK_DIV clocks, then high for TCK_DIV clocks.
REQ-015 SHALL update TMS and TDI only on the clock where TCK falls (start of the low phase).
REQ-016 SHALL sample TDO on the clock where TCK rises.
REQ-017 SHALL implement these FSM states: RST_TAP, IDLE, PRE, SHIFT, POST, RESP.
REQ-018 RST_TAP SHALL issue 5 TCK periods with TMS=1, then 1 period with TMS=0, then go to IDLE.
REQ-019 jtag_TRSTn SHALL be 0 during the first TCK period of RST_TAP and 1 at all other times outside reset.
REQ-020 In IDLE, req_ready SHALL be 1, TCK SHALL be held at 0, and TMS SHALL be held at 0.
REQ-021 A request SHALL be accepted when req_valid and req_ready are both 1; all req_* fields SHALL be registered on acceptance.
REQ-022 PRE SHALL drive the TMS prefix: DR scan 1,0,0 (3 periods); IR scan 1,1,0,0 (4 periods).
REQ-023 SHIFT SHALL run req_len periods; bit i SHALL drive TDI=req_tdi[i] and capture TDO into resp_tdo[i].
REQ-024 During SHIFT, TMS SHALL be 0 on every bit except the last, where it SHALL be 1.
REQ-025 POST SHALL drive TMS 1 then 0 (2 periods), returning the TAP to Run-Test/Idle.
REQ-026 Total TCK periods per scan SHALL be len+5 for DR and len+6 for IR.
REQ-027 resp_tdo bits at positions >= len SHALL be 0.
REQ-028 If jtag_TDO_driven is 0 at any shift sample, the controller SHALL capture 0 for that bit and set resp_undriven for that response.
REQ-029 req_len=0 SHALL produce no TCK activity; resp_valid SHALL assert on the clock after acceptance with resp_tdo=0.
REQ-030 req_len>MAX_LEN SHALL be clamped to MAX_LEN.
REQ-031 RESP SHALL hold resp_valid, resp_tdo and resp_undriven stable until resp_ready is 1.
REQ-032 req_ready SHALL be 0 whenever resp_valid is 1; the controller SHALL return to IDLE on the clock after resp_ready is sampled.
REQ-033 TCK SHALL be 0 and TMS SHALL hold its last value in RESP.

Reset
REQ-034 While reset is 1, outputs SHALL be: TCK=0, TMS=1, TDI=0, TRSTn=0, req_ready=0, resp_valid=0, resp_tdo=0, resp_undriven=0, busy=1.
REQ-035 Release of reset SHALL enter RST_TAP with its divider counter cleared.
REQ-036 Reset asserted mid-scan SHALL abort the scan, take the outputs to their reset values on the next clock edge, and discard any pending response.

Structure
REQ-037 The package jtag_scan_pkg SHALL hold the FSM state enum, the DR/IR TMS prefix constants, and the TAP-reset length (5).
REQ-038 The block SHALL contain one sub-module, jtag_tck_gen, that counts TCK_DIV and emits fall_strobe and rise_strobe one-clock pulses plus the TCK level, and that is enabled only outside IDLE and RESP.

Verification
REQ-039 Use TCK_DIV=2. Release reset -> 6 TCK pulses with TMS 1,1,1,1,1,0, TRSTn low for the first 4 clocks, then req_ready=1.
REQ-040 DR scan, len=8, tdi=0xA5, TDO looped back from TDI with driven=1 -> 13 TCK pulses, TMS 1,0,0,0,0,0,0,0,0,0,1,1,0, resp_tdo=0xA5, resp_undriven=0.
REQ-041 IR scan, len=5, tdi=0x11, driven=0 -> 11 TCK pulses, resp_tdo=0, resp_undriven=1.
REQ-042 len=64, tdi all ones, loopback -> resp_tdo all ones; then len=0 -> resp_valid one clock after acceptance, no TCK edges.
REQ-043 Hold resp_ready=0 for 20 clocks -> resp_valid and resp_tdo stable, req_ready=0, TCK stays 0.
REQ-044 Assert reset during shift bit 3 -> TCK=0 and TMS=1 on the next clock, no response delivered, RST_TAP sequence reruns after release.
